change_payout: RTL and testbench

Change-payout controller for the vending datapath: the downstream end of the coin-accept machine's `collect`/`half_out` signalling. It accepts a payout request expressed in half-dollar units and drives the dollar and half-dollar coin hoppers through a four-phase handshake. Coins are paid out greedily, dollars first, until the amount is settled, a hopper runs dry, or a hopper stops responding. It reports progress and completion to the vend sequencer.

---
 rtl/change_payout.sv | 155 +++++++++++++++
 tb/tb_change_payout.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_payout.sv
// Change-payout controller: pays a half-dollar-unit amount greedily (dollars first) through
// the dollar and half-dollar hoppers using a four-phase drop/ack handshake with a timeout.
module change_payout #(
  parameter int unsigned AMT_W   = 4,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             coin_ack,
  input  logic             one_empty,
  input  logic             half_empty,
  output logic             drop_one,
  output logic             drop_half,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] paid,
  output logic [AMT_W-1:0] remain
);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StReq,
    StRel,
    StDone,
    StFault
  } state_e;

  // Last timer value at which the awaited edge is still accepted is TIMEOUT-2; an edge seen
  // while the timer sits at TIMEOUT-1 would land as the timer reaches TIMEOUT.
  localparam logic [7:0]       TimerLast = 8'(TIMEOUT - 1);
  localparam logic [AMT_W-1:0] AmtOne    = AMT_W'(1);
  localparam logic [AMT_W-1:0] AmtTwo    = AMT_W'(2);

  state_e           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic             drop_one_q, drop_one_d;
  logic             drop_half_q, drop_half_d;
  logic             fault_q, fault_d;
  logic [AMT_W-1:0] paid_q, paid_d;
  logic [AMT_W-1:0] remain_q, remain_d;
  logic             timeout_hit;

  assign timeout_hit = (timer_q == TimerLast);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    drop_one_d  = drop_one_q;
    drop_half_d = drop_half_q;
    fault_d     = fault_q;
    paid_d      = paid_q;
    remain_d    = remain_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          remain_d = amount;
          paid_d   = '0;
          fault_d  = 1'b0;
          state_d  = StSelect;
        end
      end
      StSelect: begin
        if (remain_q == '0) begin
          state_d = StDone;
        end else if (remain_q >= AmtTwo && !one_empty) begin
          drop_one_d = 1'b1;
          timer_d    = '0;
          state_d    = StReq;
        end else if (!half_empty) begin
          drop_half_d = 1'b1;
          timer_d     = '0;
          state_d     = StReq;
        end else begin
          state_d = StFault;
        end
      end
      StReq: begin
        if (timeout_hit) begin
          drop_one_d  = 1'b0;
          drop_half_d = 1'b0;
          state_d     = StFault;
        end else if (coin_ack) begin
          drop_one_d  = 1'b0;
          drop_half_d = 1'b0;
          if (drop_one_q) begin
            remain_d = remain_q - AmtTwo;
            paid_d   = paid_q + AmtTwo;
          end else begin
            remain_d = remain_q - AmtOne;
            paid_d   = paid_q + AmtOne;
          end
          timer_d = '0;
          state_d = StRel;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StRel: begin
        if (timeout_hit) begin
          drop_one_d  = 1'b0;
          drop_half_d = 1'b0;
          state_d     = StFault;
        end else if (!coin_ack) begin
          state_d = StSelect;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StFault: begin
        fault_d = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      drop_one_q  <= 1'b0;
      drop_half_q <= 1'b0;
      fault_q     <= 1'b0;
      paid_q      <= '0;
      remain_q    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      drop_one_q  <= drop_one_d;
      drop_half_q <= drop_half_d;
      fault_q     <= fault_d;
      paid_q      <= paid_d;
      remain_q    <= remain_d;
    end
  end

  assign drop_one  = drop_one_q;
  assign drop_half = drop_half_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign fault     = fault_q;
  assign paid      = paid_q;
  assign remain    = remain_q;

endmodule

// File: tb/tb_change_payout.sv
// Scoreboard bench for change_payout: a driver queues expected transaction outcomes from a
// greedy payout model, a hopper model answers drops, and a monitor checks each completion.
module tb_change_payout;

  localparam int unsigned AMT_W   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic             clk;
  logic             reset;
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             coin_ack;
  logic             one_empty;
  logic             half_empty;
  logic             drop_one;
  logic             drop_half;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] paid;
  logic [AMT_W-1:0] remain;

  change_payout #(
    .AMT_W  (AMT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .amount    (amount),
    .coin_ack  (coin_ack),
    .one_empty (one_empty),
    .half_empty(half_empty),
    .drop_one  (drop_one),
    .drop_half (drop_half),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .paid      (paid),
    .remain    (remain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int paid;
    int remain;
    int fault;
    int done_cnt;
    int n_one;
    int n_half;
    int stalled;
    int busy_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Hopper behaviour knobs, set by the driver per transaction.
  int ack_dly = 0;
  int rel_dly = 0;
  int stall_at = -1;
  int coin_idx = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Greedy payout from the rules: dollars while >= 1.00 owed and stocked, else halves.
  task automatic model_push(input int amt, input bit oe, input bit he, input int stall);
    exp_t e;
    int   rem;
    int   ncoin;
    int   v;
    e = '{paid: 0, remain: 0, fault: 0, done_cnt: 0, n_one: 0, n_half: 0, stalled: 0,
          busy_cyc: -1};
    rem   = amt;
    ncoin = 0;
    while (rem > 0) begin
      if (rem >= 2 && !oe) v = 2;
      else if (!he) v = 1;
      else begin
        e.fault = 1;
        break;
      end
      ncoin++;
      if (v == 2) e.n_one++;
      else e.n_half++;
      if (ncoin == stall) begin
        e.fault   = 1;
        e.stalled = 1;
        break;
      end
      e.paid += v;
      rem    -= v;
    end
    e.remain   = amt - e.paid;
    e.done_cnt = e.fault ? 0 : 1;
    if (amt == 0) e.busy_cyc = 2;
    exp_q.push_back(e);
  endtask

  // Hopper: raise ack ack_dly cycles after a drop rises, drop it rel_dly cycles after release.
  initial begin
    int  hcnt;
    bit  hprev;
    bit  d;
    coin_ack = 1'b0;
    hcnt     = 0;
    hprev    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        coin_ack = 1'b0;
        hcnt     = 0;
        hprev    = 1'b0;
      end else begin
        d = drop_one | drop_half;
        if (d && !hprev) begin
          coin_idx++;
          hcnt = 0;
        end
        if (d && !coin_ack) begin
          if (coin_idx != stall_at) begin
            if (hcnt >= ack_dly) begin
              coin_ack = 1'b1;
              hcnt     = 0;
            end else hcnt++;
          end
        end else if (!d && coin_ack) begin
          if (hcnt >= rel_dly) begin
            coin_ack = 1'b0;
            hcnt     = 0;
          end else hcnt++;
        end else begin
          hcnt = 0;
        end
        hprev = d;
      end
    end
  end

  // Monitor: gathers per-transaction observations, compares when busy falls.
  initial begin
    bit   prev_busy, prev_one, prev_half;
    int   busy_cyc, done_cnt, n_one, n_half, excl, run, max_run;
    exp_t e;
    prev_busy = 0;
    prev_one  = 0;
    prev_half = 0;
    busy_cyc  = 0;
    done_cnt  = 0;
    n_one     = 0;
    n_half    = 0;
    excl      = 0;
    run       = 0;
    max_run   = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_busy = 0;
        prev_one  = 0;
        prev_half = 0;
      end else begin
        if (busy && !prev_busy) begin
          busy_cyc = 0;
          done_cnt = 0;
          n_one    = 0;
          n_half   = 0;
          excl     = 0;
          run      = 0;
          max_run  = 0;
        end
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (drop_one && !prev_one) n_one++;
        if (drop_half && !prev_half) n_half++;
        if (drop_one && drop_half) excl++;
        if (drop_one || drop_half) run++;
        else run = 0;
        if (run > max_run) max_run = run;
        if (!busy && prev_busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_txn", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("paid", int'(paid), e.paid);
            check("remain", int'(remain), e.remain);
            check("fault", int'(fault), e.fault);
            check("done_pulses", done_cnt, e.done_cnt);
            check("drop_one_count", n_one, e.n_one);
            check("drop_half_count", n_half, e.n_half);
            check("drop_exclusive", excl, 0);
            if (e.stalled != 0) check("drop_timeout_len", max_run, TIMEOUT);
            else check("drop_len_below_timeout", int'(max_run < TIMEOUT), 1);
            if (e.busy_cyc >= 0) check("busy_cycles", busy_cyc, e.busy_cyc);
          end
        end
        prev_busy = busy;
        prev_one  = drop_one;
        prev_half = drop_half;
      end
    end
  end

  task automatic run_txn(input int amt, input bit oe, input bit he, input int stall,
                         input int k, input int j, input bit glitch);
    int cyc;
    ack_dly    = k;
    rel_dly    = j;
    stall_at   = stall;
    coin_idx   = 0;
    one_empty  = oe;
    half_empty = he;
    model_push(amt, oe, he, stall);
    req    = 1'b1;
    amount = AMT_W'(amt);
    @(posedge clk);
    #1;
    req    = 1'b0;
    amount = AMT_W'($urandom);
    if (glitch) begin
      repeat (2) @(posedge clk);
      #1;
      if (busy) begin
        req    = 1'b1;
        amount = ~AMT_W'(amt);
        @(posedge clk);
        #1;
        req = 1'b0;
      end
    end
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (busy) check("txn_completes", 0, 1);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    reset      = 1'b0;
    req        = 1'b0;
    amount     = '0;
    one_empty  = 1'b0;
    half_empty = 1'b0;
    #12;
    check("reset_drop_one", int'(drop_one), 0);
    check("reset_drop_half", int'(drop_half), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_fault", int'(fault), 0);
    check("reset_paid", int'(paid), 0);
    check("reset_remain", int'(remain), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    run_txn(5, 0, 0, -1, 2, 1, 0);
    run_txn(0, 0, 0, -1, 0, 0, 0);
    run_txn(3, 1, 0, -1, 1, 0, 0);
    run_txn(2, 1, 1, -1, 0, 0, 0);
    run_txn(1, 1, 0, -1, 0, 0, 0);
    run_txn(4, 0, 0, 1, 0, 0, 0);
    run_txn(15, 0, 0, -1, 3, 3, 1);
    run_txn(7, 0, 1, -1, 0, 2, 0);

    // Randomised transactions.
    for (int t = 0; t < 60; t++) begin
      int amt;
      int stall;
      amt   = int'($urandom_range(15, 0));
      stall = ($urandom_range(99, 0) < 15) ? int'($urandom_range(8, 1)) : -1;
      run_txn(amt, $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0, stall,
              int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
              $urandom_range(9, 0) < 3);
    end

    // Asynchronous reset while a dollar drop is pending.
    ack_dly    = 3;
    rel_dly    = 0;
    stall_at   = -1;
    coin_idx   = 0;
    one_empty  = 1'b0;
    half_empty = 1'b0;
    req        = 1'b1;
    amount     = AMT_W'(4);
    @(posedge clk);
    #1;
    req = 1'b0;
    cyc = 0;
    while (!drop_one && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drop_before_reset", int'(drop_one), 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_drop_one", int'(drop_one), 0);
    check("async_busy", int'(busy), 0);
    check("async_paid", int'(paid), 0);
    check("async_remain", int'(remain), 0);
    check("async_fault", int'(fault), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_txn(6, 0, 0, -1, 1, 1, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
